led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_pkg.sv | 13 +
 rtl/led_prescaler.sv | 20 ++
 rtl/led_sequencer.sv | 79 +++++++
 tb/tb_led_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared mode and bounce-direction encodings for the LED sequencer
package led_pkg;
    typedef enum logic [1:0] {
        MODE_BIN    = 2'd0,
        MODE_ROT    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_GRAY   = 2'd3
    } mode_e;
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;
endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: clock-enable step generator, one step every DIV+1 enabled cycles
module led_prescaler #(
    parameter int DIV_WIDTH = 24
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 EN,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] DIV,
    output logic                 tick
);
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = EN && !clr && cnt_q >= DIV;
        cnt_d = (clr || tick) ? '0 : EN ? cnt_q + DIV_WIDTH'(1) : cnt_q;
    end
    always_ff @(posedge CLK) begin
        cnt_q <= !RESET ? '0 : cnt_d;
    end
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: prescaled LED pattern generator with binary, rotate, bounce and gray modes
module led_sequencer
    import led_pkg::*;
#(
    parameter int NUM_LEDS  = 4,
    parameter int DIV_WIDTH = 24
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 EN,
    input  logic [DIV_WIDTH-1:0] DIV,
    input  logic [1:0]           MODE,
    output logic [NUM_LEDS-1:0]  LEDS,
    output logic                 TICK
);
    mode_e               mode_q, mode_d;
    dir_e                dir_q, dir_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d, b_q, b_d, b_inc, shl, shr;
    logic                tick_q, tick, mode_chg;

    led_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (EN),
        .clr   (mode_chg),
        .DIV   (DIV),
        .tick  (tick)
    );

    always_comb begin
        mode_d   = mode_e'(MODE);
        mode_chg = mode_d != mode_q;
        b_inc    = b_q + NUM_LEDS'(1);
        shl      = leds_q << 1;
        shr      = leds_q >> 1;
        leds_d   = leds_q;
        b_d      = b_q;
        dir_d    = dir_q;
        if (mode_chg) begin
            leds_d = (mode_d == MODE_ROT || mode_d == MODE_BOUNCE) ? NUM_LEDS'(1) : '0;
            b_d    = '0;
            dir_d  = DIR_UP;
        end else if (tick) begin
            case (mode_q)
                MODE_BIN: leds_d = leds_q + NUM_LEDS'(1);
                MODE_ROT: leds_d = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
                MODE_BOUNCE: begin
                    leds_d = (dir_q == DIR_UP) ? shl : shr;
                    // reverse as soon as an endpoint is reached so it shows for one tick only
                    dir_d  = (dir_q == DIR_UP) ? (shl[NUM_LEDS-1] ? DIR_DOWN : DIR_UP)
                                               : (shr[0] ? DIR_UP : DIR_DOWN);
                end
                MODE_GRAY: begin
                    b_d    = b_inc;
                    leds_d = b_inc ^ (b_inc >> 1);
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            mode_q <= MODE_BIN;
            dir_q  <= DIR_UP;
            leds_q <= '0;
            b_q    <= '0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            leds_q <= leds_d;
            b_q    <= b_d;
            tick_q <= tick;
        end
    end

    assign LEDS = leds_q;
    assign TICK = tick_q;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed and randomized checks of led_sequencer against a step-count pattern model
module tb_led_sequencer;
    localparam int N  = 4;
    localparam int DW = 24;

    logic          CLK = 1'b0;
    logic          RESET, EN;
    logic [DW-1:0] DIV;
    logic [1:0]    MODE;
    logic [N-1:0]  LEDS;
    logic          TICK;

    int total = 0, bad = 0;
    bit chk_on = 0;
    int m_cnt = 0, m_k = 0, m_mode = 0;
    bit m_tick = 0;

    led_sequencer #(.NUM_LEDS(N), .DIV_WIDTH(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (EN),
        .DIV   (DIV),
        .MODE  (MODE),
        .LEDS  (LEDS),
        .TICK  (TICK)
    );

    always #5 CLK = ~CLK;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // pattern after k steps since the last mode load, straight from each mode's definition
    function automatic logic [N-1:0] pat(int m, int k);
        int p;
        case (m)
            0: return N'(k % (1 << N));
            1: return N'(1 << (k % N));
            2: begin
                p = k % (2 * N - 2);
                return N'(1 << (p < N ? p : 2 * N - 2 - p));
            end
            default: begin
                p = k % (1 << N);
                return N'(p ^ (p >> 1));
            end
        endcase
    endfunction

    always @(posedge CLK) begin
        if (!RESET) begin
            m_cnt = 0; m_k = 0; m_mode = 0; m_tick = 0;
        end else if (int'(MODE) != m_mode) begin
            m_mode = int'(MODE); m_cnt = 0; m_k = 0; m_tick = 0;
        end else if (EN) begin
            if (m_cnt >= int'(DIV)) begin
                m_cnt = 0; m_tick = 1; m_k++;
            end else begin
                m_cnt++; m_tick = 0;
            end
        end else begin
            m_tick = 0;
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            check("model_tick", TICK, m_tick);
            check("model_leds", LEDS, pat(m_mode, m_k));
        end
    end

    initial begin
        logic [N-1:0] bounce_exp [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        logic [N-1:0] prev;
        int n;
        RESET = 0; EN = 0; DIV = '0; MODE = 2'd0;
        repeat (2) @(negedge CLK);
        chk_on = 1;
        check("rst_leds", LEDS, 0);
        check("rst_tick", TICK, 0);

        DIV = DW'(3); EN = 1; RESET = 1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge CLK); #1;
            check("div3_tick", TICK, (e % 4 == 0));
            check("div3_leds", LEDS, e / 4);
        end

        @(negedge CLK); RESET = 0; DIV = '0;
        @(negedge CLK); RESET = 1;
        for (int e = 1; e <= 16; e++) begin
            @(posedge CLK); #1;
            check("bin_leds", LEDS, e % 16);
            check("bin_tick", TICK, 1);
        end

        @(negedge CLK); MODE = 2'd2;
        for (int e = 0; e < 8; e++) begin
            @(posedge CLK); #1;
            check("bounce_leds", LEDS, bounce_exp[e]);
            if (e == 0) check("bounce_load_tick", TICK, 0);
        end

        @(negedge CLK); MODE = 2'd3;
        @(posedge CLK); #1;
        check("gray_load", LEDS, 0);
        prev = LEDS;
        for (int e = 0; e < 16; e++) begin
            @(posedge CLK); #1;
            check("gray_one_bit", $countones(LEDS ^ prev), 1);
            prev = LEDS;
        end
        check("gray_wrap", LEDS, 0);

        @(negedge CLK); MODE = 2'd1; DIV = DW'(7);
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (!TICK && n < 20);
        check("rot_first_step", n, 9);
        n = 0;
        do begin
            @(negedge CLK); EN = !(n >= 2 && n < 7);
            @(posedge CLK); #1; n++;
            if (!EN) check("frozen_tick", TICK, 0);
        end while (!TICK && n < 30);
        check("pause_period", n, 13);
        check("rot_leds", LEDS, 4);

        @(negedge CLK); DIV = DW'(9);
        n = 0;
        while (m_cnt != 6 && n < 30) begin @(negedge CLK); n++; end
        check("reach_cnt6", n < 30, 1);
        DIV = DW'(2);
        @(posedge CLK); #1;
        check("div_lowered_tick", TICK, 1);

        @(negedge CLK);
        n = 0;
        while (m_cnt != 2 && n < 30) begin @(negedge CLK); n++; end
        check("reach_cnt2", n < 30, 1);
        MODE = 2'd0;
        @(posedge CLK); #1;
        check("chg_tick", TICK, 0);
        check("chg_leds", LEDS, 0);
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (!TICK && n < 20);
        check("chg_first_step", n, 3);
        check("chg_first_leds", LEDS, 1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            EN = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 15) == 0) DIV = DW'($urandom_range(0, 5));
            if ($urandom_range(0, 60) == 0) MODE = 2'($urandom_range(0, 3));
            RESET = $urandom_range(0, 250) != 0;
        end
        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
